// File: rtl/e_mdu.sv
// Multi-cycle multiply/divide unit for the E stage; owns HI/LO and serves mthi/mtlo/mfhi/mflo.
// Results are computed at the accept edge and held pending until the busy window ends.
`timescale 1ns/1ps
module e_mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  MD_op,
  input  logic        start,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MD_out
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = ($clog2(MaxCycles + 1) > 4) ? $clog2(MaxCycles + 1) : 4;
  localparam logic [CntW-1:0] CntOne    = 1;
  localparam logic [CntW-1:0] MultCount = MULT_CYCLES[CntW-1:0];
  localparam logic [CntW-1:0] DivCount  = DIV_CYCLES[CntW-1:0];

  localparam logic [3:0] OpMult  = 4'd1;
  localparam logic [3:0] OpMultu = 4'd2;
  localparam logic [3:0] OpDiv   = 4'd3;
  localparam logic [3:0] OpDivu  = 4'd4;
  localparam logic [3:0] OpMfhi  = 4'd5;
  localparam logic [3:0] OpMflo  = 4'd6;
  localparam logic [3:0] OpMthi  = 4'd7;
  localparam logic [3:0] OpMtlo  = 4'd8;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [31:0]     hi_p_q, lo_p_q;

  logic [63:0]     prod_s, prod_u;
  logic [31:0]     a_mag, b_mag, q_mag, r_mag;
  logic [31:0]     quo_s, rem_s, quo_u, rem_u;
  logic            b_zero;
  logic            calc_go;
  logic [31:0]     calc_hi, calc_lo;
  logic [CntW-1:0] calc_cnt;

  always_comb begin
    prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    prod_u = {32'd0, A} * {32'd0, B};
    b_zero = (B == 32'd0);
    // Signed divide via magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
    a_mag  = A[31] ? (32'd0 - A) : A;
    b_mag  = B[31] ? (32'd0 - B) : B;
    q_mag  = b_zero ? 32'd0 : (a_mag / b_mag);
    r_mag  = b_zero ? 32'd0 : (a_mag % b_mag);
    quo_s  = (A[31] ^ B[31]) ? (32'd0 - q_mag) : q_mag;
    rem_s  = A[31] ? (32'd0 - r_mag) : r_mag;
    quo_u  = b_zero ? 32'd0 : (A / B);
    rem_u  = b_zero ? 32'd0 : (A % B);
  end

  always_comb begin
    calc_go  = 1'b0;
    calc_hi  = HI;
    calc_lo  = LO;
    calc_cnt = MultCount;
    case (MD_op)
      OpMult:  begin calc_go = 1'b1; {calc_hi, calc_lo} = prod_s; end
      OpMultu: begin calc_go = 1'b1; {calc_hi, calc_lo} = prod_u; end
      // Divide by zero commits the current HI/LO, i.e. leaves them unchanged.
      OpDiv: begin
        calc_go  = 1'b1;
        calc_cnt = DivCount;
        if (!b_zero) begin
          calc_hi = rem_s;
          calc_lo = quo_s;
        end
      end
      OpDivu: begin
        calc_go  = 1'b1;
        calc_cnt = DivCount;
        if (!b_zero) begin
          calc_hi = rem_u;
          calc_lo = quo_u;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      busy    <= 1'b0;
      cnt_q   <= '0;
      hi_p_q  <= '0;
      lo_p_q  <= '0;
      HI      <= '0;
      LO      <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start && calc_go) begin
            hi_p_q  <= calc_hi;
            lo_p_q  <= calc_lo;
            cnt_q   <= calc_cnt;
            state_q <= StRun;
            busy    <= 1'b1;
          end else if (start && MD_op == OpMthi) begin
            HI <= A;
          end else if (start && MD_op == OpMtlo) begin
            LO <= A;
          end
        end
        StRun: begin
          cnt_q <= cnt_q - CntOne;
          if (cnt_q == CntOne) begin
            HI      <= hi_p_q;
            LO      <= lo_p_q;
            state_q <= StIdle;
            busy    <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    MD_out = 32'd0;
    if (MD_op == OpMfhi) MD_out = HI;
    else if (MD_op == OpMflo) MD_out = LO;
  end

endmodule

// File: tb/tb_e_mdu.sv
// Directed bench for e_mdu: arithmetic results, busy window length, ignored issues and reset.
`timescale 1ns/1ps
module tb_e_mdu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] A, B;
  logic [3:0]  MD_op;
  logic        start;
  logic        busy;
  logic [31:0] HI, LO, MD_out;

  int vectors = 0;
  int errors  = 0;
  int n;

  e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .A      (A),
    .B      (B),
    .MD_op  (MD_op),
    .start  (start),
    .busy   (busy),
    .HI     (HI),
    .LO     (LO),
    .MD_out (MD_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drive an issue at a negedge; returns at the following negedge with start dropped.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    MD_op = op; A = a; B = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; MD_op = 4'd0;
  endtask

  // Count negedges with busy high, starting from the current negedge; bounded.
  task automatic wait_idle(input int already, output int cnt);
    cnt = already;
    while (busy && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int cyc, input logic [31:0] ehi,
                        input logic [31:0] elo);
    int c;
    issue(op, a, b);
    wait_idle(0, c);
    check({tag, " busy cycles"}, 32'(c), 32'(cyc));
    check({tag, " HI"}, HI, ehi);
    check({tag, " LO"}, LO, elo);
  endtask

  initial begin
    rst_n = 1'b0; A = '0; B = '0; MD_op = 4'd5; start = 1'b0;
    repeat (2) @(negedge clk);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset HI", HI, 32'd0);
    check("reset LO", LO, 32'd0);
    check("reset MD_out mfhi", MD_out, 32'd0);
    MD_op = 4'd0;
    rst_n = 1'b1;

    run_op("mult -1*2", 4'd1, 32'hFFFFFFFF, 32'd2, 5, 32'hFFFFFFFF, 32'hFFFFFFFE);
    run_op("multu ffffffff*2", 4'd2, 32'hFFFFFFFF, 32'd2, 5, 32'h00000001, 32'hFFFFFFFE);
    run_op("div -7/2", 4'd3, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu fffffff9/2", 4'd4, 32'hFFFFFFF9, 32'd2, 10, 32'h00000001, 32'h7FFFFFFC);
    run_op("div ovf", 4'd3, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000);

    // mthi / mtlo: one edge each, busy stays low
    issue(4'd7, 32'h12345678, 32'd0);
    check("mthi HI", HI, 32'h12345678);
    check("mthi busy", {31'd0, busy}, 32'd0);
    issue(4'd8, 32'h9ABCDEF0, 32'd0);
    check("mtlo LO", LO, 32'h9ABCDEF0);
    check("mtlo HI kept", HI, 32'h12345678);
    check("mtlo busy", {31'd0, busy}, 32'd0);
    MD_op = 4'd5; #1;
    check("mfhi MD_out", MD_out, 32'h12345678);
    MD_op = 4'd6; #1;
    check("mflo MD_out", MD_out, 32'h9ABCDEF0);
    MD_op = 4'd9; #1;
    check("op9 MD_out", MD_out, 32'd0);
    MD_op = 4'd0;

    // Divide by zero with ignored issues during busy
    issue(4'd7, 32'h11111111, 32'd0);
    issue(4'd8, 32'h11111111, 32'd0);
    @(negedge clk);
    MD_op = 4'd3; A = 32'd77; B = 32'd0; start = 1'b1;
    @(negedge clk);
    check("div0 busy rise", {31'd0, busy}, 32'd1);
    MD_op = 4'd1; A = 32'd3; B = 32'd4;
    @(negedge clk);
    MD_op = 4'd7; A = 32'hDEADBEEF;
    @(negedge clk);
    start = 1'b0; MD_op = 4'd0;
    check("div0 HI during busy", HI, 32'h11111111);
    wait_idle(2, n);
    check("div0 busy cycles", 32'(n), 32'd10);
    check("div0 HI", HI, 32'h11111111);
    check("div0 LO", LO, 32'h11111111);
    @(negedge clk);
    check("div0 no restart", {31'd0, busy}, 32'd0);
    check("div0 HI after idle", HI, 32'h11111111);

    // Asynchronous reset in the 4th busy cycle
    issue(4'd3, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    check("pre-reset busy", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async rst busy", {31'd0, busy}, 32'd0);
    check("async rst HI", HI, 32'd0);
    check("async rst LO", LO, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("discarded div HI", HI, 32'd0);
    check("discarded div LO", LO, 32'd0);
    run_op("multu 3*4", 4'd2, 32'd3, 32'd4, 5, 32'd0, 32'd12);

    // Back-to-back: second start in first idle cycle
    issue(4'd1, 32'hFFFFFFFD, 32'd5);
    wait_idle(0, n);
    check("b2b first busy cycles", 32'(n), 32'd5);
    check("b2b first HI", HI, 32'hFFFFFFFF);
    check("b2b first LO", LO, 32'hFFFFFFF1);
    MD_op = 4'd2; A = 32'h00010000; B = 32'h00010000; start = 1'b1;
    @(negedge clk);
    start = 1'b0; MD_op = 4'd0;
    check("b2b second accepted", {31'd0, busy}, 32'd1);
    wait_idle(0, n);
    check("b2b second busy cycles", 32'(n), 32'd5);
    check("b2b second HI", HI, 32'd1);
    check("b2b second LO", LO, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
